// File: rtl/gbt_link_reset_sequencer.sv
// GBT transceiver bank bring-up / recovery sequencer (40 MHz frame-clock domain).
// Drives the bank general reset and manual RX reset from PLL lock, SFP LOS and
// GBT TX/RX ready. Retries on timeouts and escalates repeated RX failures to a
// full general reset. Exports link-up, state and saturating diagnostic counters.
//
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  WAIT_PLL | bank held in general reset until PLL locked and LOS clear
//  GEN_RST  | general reset pulse of RESET_CYCLES, RX attempts cleared
//  WAIT_TX  | waiting for TX ready, retries general reset after TX_TIMEOUT
//  RX_RST   | manual RX reset pulse of RESET_CYCLES
//  WAIT_RX  | waiting for RX_STABLE consecutive RX ready, retries RX reset
//  LINK_UP  | link established, watching TX/RX ready for loss
module gbt_link_reset_sequencer #(
    parameter int RESET_CYCLES   = 16,
    parameter int TX_TIMEOUT     = 4000000,
    parameter int RX_TIMEOUT     = 4000000,
    parameter int RX_STABLE      = 1024,
    parameter int MAX_RX_RETRIES = 4,
    parameter int LOS_FILTER     = 8
) (
    input  logic       clk_ik,
    input  logic       rstn_ir,
    input  logic       pll_locked_i,
    input  logic       sfp_los_i,
    input  logic       gbt_tx_ready_i,
    input  logic       gbt_rx_ready_i,
    input  logic       clr_counters_i,
    output logic       general_reset_o,
    output logic       manual_reset_rx_o,
    output logic       link_up_o,
    output logic [2:0] state_o,
    output logic [7:0] gen_retry_cnt_o,
    output logic [7:0] rx_retry_cnt_o,
    output logic [7:0] link_lost_cnt_o
);

    localparam int T_MAX_A = (TX_TIMEOUT > RX_TIMEOUT) ? TX_TIMEOUT : RX_TIMEOUT;
    localparam int T_MAX_B = (RESET_CYCLES > RX_STABLE) ? RESET_CYCLES : RX_STABLE;
    localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int TW      = $clog2(T_MAX) + 1;
    localparam int LW      = $clog2(LOS_FILTER) + 1;
    localparam int AW      = $clog2(MAX_RX_RETRIES) + 1;

    // Terminal counts: a state lasting N cycles exits when its timer reads N-1.
    localparam logic [TW-1:0] RST_TC = TW'(RESET_CYCLES - 1);
    localparam logic [TW-1:0] TX_TC  = TW'(TX_TIMEOUT - 1);
    localparam logic [TW-1:0] RX_TC  = TW'(RX_TIMEOUT - 1);
    localparam logic [TW-1:0] STB_TC = TW'(RX_STABLE - 1);
    localparam logic [LW-1:0] LOS_TC = LW'(LOS_FILTER - 1);
    localparam logic [AW-1:0] ATT_MAX = AW'(MAX_RX_RETRIES);

    typedef enum logic [2:0] {
        WAIT_PLL = 3'd0,
        GEN_RST  = 3'd1,
        WAIT_TX  = 3'd2,
        RX_RST   = 3'd3,
        WAIT_RX  = 3'd4,
        LINK_UP  = 3'd5
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   stable_cnt;
    logic [AW-1:0]   attempt;
    logic [AW-1:0]   attempt_nxt;
    logic            los_f;
    logic [LW-1:0]   los_run;
    logic            inc_gen;
    logic            inc_rx;
    logic            inc_lost;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign state_o = state;

    // LOS filter: los_f follows sfp_los_i only after LOS_FILTER consecutive disagreeing samples.
    always_ff @(posedge clk_ik) begin
        if (!rstn_ir) begin
            los_f   <= 1'b1;
            los_run <= '0;
        end else if (sfp_los_i != los_f) begin
            if (los_run == LOS_TC) begin
                los_f   <= sfp_los_i;
                los_run <= '0;
            end else begin
                los_run <= los_run + 1'b1;
            end
        end else begin
            los_run <= '0;
        end
    end

    // Next-state logic; the global abort overrides every per-state transition.
    always_comb begin
        state_nxt   = state;
        attempt_nxt = attempt;
        inc_gen     = 1'b0;
        inc_rx      = 1'b0;
        inc_lost    = 1'b0;
        if (state != WAIT_PLL && (!pll_locked_i || los_f)) begin
            state_nxt = WAIT_PLL;
            inc_lost  = (state == LINK_UP);
        end else begin
            case (state)
                WAIT_PLL: begin
                    if (pll_locked_i && !los_f) state_nxt = GEN_RST;
                end
                GEN_RST: begin
                    if (timer == RST_TC) state_nxt = WAIT_TX;
                end
                WAIT_TX: begin
                    if (gbt_tx_ready_i) begin
                        state_nxt = RX_RST;
                    end else if (timer == TX_TC) begin
                        state_nxt = GEN_RST;
                        inc_gen   = 1'b1;
                    end
                end
                RX_RST: begin
                    if (timer == RST_TC) state_nxt = WAIT_RX;
                end
                WAIT_RX: begin
                    if (gbt_rx_ready_i && stable_cnt == STB_TC) begin
                        state_nxt = LINK_UP;
                    end else if (!gbt_tx_ready_i) begin
                        state_nxt = GEN_RST;
                    end else if (timer == RX_TC) begin
                        inc_rx      = 1'b1;
                        attempt_nxt = attempt + 1'b1;
                        state_nxt   = (attempt_nxt >= ATT_MAX) ? GEN_RST : RX_RST;
                    end
                end
                LINK_UP: begin
                    if (!gbt_tx_ready_i) begin
                        state_nxt = GEN_RST;
                        inc_lost  = 1'b1;
                    end else if (!gbt_rx_ready_i) begin
                        state_nxt   = RX_RST;
                        attempt_nxt = '0;
                        inc_lost    = 1'b1;
                    end
                end
                default: state_nxt = WAIT_PLL;
            endcase
        end
        // Every entry into GEN_RST starts a fresh round of RX attempts.
        if (state_nxt == GEN_RST) attempt_nxt = '0;
    end

    // State, timers and registered Moore outputs decoded from the next state.
    always_ff @(posedge clk_ik) begin
        if (!rstn_ir) begin
            state             <= WAIT_PLL;
            timer             <= '0;
            stable_cnt        <= '0;
            attempt           <= '0;
            general_reset_o   <= 1'b1;
            manual_reset_rx_o <= 1'b0;
            link_up_o         <= 1'b0;
        end else begin
            state   <= state_nxt;
            attempt <= attempt_nxt;
            if (state_nxt != state) begin
                timer      <= '0;
                stable_cnt <= '0;
            end else begin
                if (timer != '1) timer <= timer + 1'b1;
                stable_cnt <= (state == WAIT_RX && gbt_rx_ready_i) ? stable_cnt + 1'b1 : '0;
            end
            general_reset_o   <= (state_nxt == WAIT_PLL) || (state_nxt == GEN_RST);
            manual_reset_rx_o <= (state_nxt == RX_RST);
            link_up_o         <= (state_nxt == LINK_UP);
        end
    end

    // Saturating diagnostic counters; a clear wins over a simultaneous increment.
    always_ff @(posedge clk_ik) begin
        if (!rstn_ir || clr_counters_i) begin
            gen_retry_cnt_o <= '0;
            rx_retry_cnt_o  <= '0;
            link_lost_cnt_o <= '0;
        end else begin
            if (inc_gen)  gen_retry_cnt_o <= sat_inc(gen_retry_cnt_o);
            if (inc_rx)   rx_retry_cnt_o  <= sat_inc(rx_retry_cnt_o);
            if (inc_lost) link_lost_cnt_o <= sat_inc(link_lost_cnt_o);
        end
    end

endmodule

// File: doc/gbt_link_reset_sequencer.md
Name: gbt_link_reset_sequencer

Overview:
- Sequences bring-up and recovery of the GBT transceiver bank in the 40 MHz frame-clock domain.
- Drives the bank's general reset and manual RX reset, which the top level currently ties low, from PLL lock, SFP loss-of-signal and GBT TX/RX ready status.
- Retries with timeouts, escalates repeated RX failures to a full reset, and exports link-up, state and diagnostic counters to the system logic.

Parameters:
RESET_CYCLES, 16, cycles a reset output is held high per pulse (>=1)
TX_TIMEOUT, 4000000, max cycles in WAIT_TX before retrying the general reset (100 ms at 40 MHz)
RX_TIMEOUT, 4000000, max cycles in WAIT_RX before retrying the RX reset
RX_STABLE, 1024, consecutive rx_ready cycles required to declare the link up
MAX_RX_RETRIES, 4, RX-reset attempts per general reset before escalating
LOS_FILTER, 8, consecutive equal samples needed to change the filtered LOS

Ports:
clk_ik  in  1  40 MHz frame clock
rstn_ir  in  1  synchronous reset, active low
pll_locked_i  in  1  frame-clock PLL lock
sfp_los_i  in  1  SFP loss of signal, synchronized upstream
gbt_tx_ready_i  in  1  GBT TX ready
gbt_rx_ready_i  in  1  GBT RX ready
clr_counters_i  in  1  one-cycle pulse that zeroes all diagnostic counters
general_reset_o  out  1  to gbtbank_general_reset_i
manual_reset_rx_o  out  1  to gbtbank_manual_reset_rx_i
link_up_o  out  1  link established and stable
state_o  out  3  current state encoding
gen_retry_cnt_o  out  8  general-reset timeouts (saturating)
rx_retry_cnt_o  out  8  RX-reset timeouts (saturating)
link_lost_cnt_o  out  8  exits from LINK_UP (saturating)

Behaviour:
- Clocking and reset: one clock, clk_ik. Reset is synchronous and active-low on rstn_ir; no asynchronous reset anywhere.
- All outputs are registered and decoded from the state register (Moore machine).
- State encoding: WAIT_PLL=0, GEN_RST=1, WAIT_TX=2, RX_RST=3, WAIT_RX=4, LINK_UP=5. Codes 6 and 7 return to WAIT_PLL.
- Values while rstn_ir=0:
  - state=WAIT_PLL, general_reset_o=1, manual_reset_rx_o=0, link_up_o=0
  - all counters=0, timer=0, attempt=0
  - filtered LOS (los_f)=1
- los_f filter: los_f changes only after sfp_los_i has differed from los_f for LOS_FILTER consecutive cycles. Any mismatch-free cycle restarts the run count.
- Global abort (highest priority, any state except WAIT_PLL): pll_locked_i=0 or los_f=1 -> WAIT_PLL on the next cycle. If the state was LINK_UP, link_lost_cnt increments.
- WAIT_PLL: general_reset_o=1. When pll_locked_i=1 and los_f=0 -> GEN_RST.
- GEN_RST:
  - general_reset_o=1 for exactly RESET_CYCLES cycles, then -> WAIT_TX.
  - attempt is cleared on entry.
- WAIT_TX: timer counts cycles spent in the state.
  - gbt_tx_ready_i=1 -> RX_RST.
  - Otherwise, after TX_TIMEOUT cycles -> GEN_RST and gen_retry_cnt+1.
  - If ready and timeout occur in the same cycle, ready wins.
- RX_RST: manual_reset_rx_o=1 for exactly RESET_CYCLES cycles, then -> WAIT_RX.
- WAIT_RX:
  - Stability counter counts consecutive gbt_rx_ready_i=1 cycles and clears on any 0.
  - Reaching RX_STABLE -> LINK_UP.
  - gbt_tx_ready_i=0 -> GEN_RST.
  - After RX_TIMEOUT cycles without reaching stability: rx_retry_cnt+1 and attempt+1. If attempt reaches MAX_RX_RETRIES -> GEN_RST, else -> RX_RST.
  - Stability has priority over timeout in the same cycle.
- LINK_UP: link_up_o=1.
  - gbt_tx_ready_i=0 -> GEN_RST.
  - Else gbt_rx_ready_i=0 -> RX_RST with attempt=0.
  - Either exit increments link_lost_cnt. If both drop in the same cycle, GEN_RST is taken and the counter increments once.
- Timer: width $clog2(max(TX_TIMEOUT, RX_TIMEOUT, RESET_CYCLES, RX_STABLE))+1. Cleared on every state change.
- Counters:
  - saturate at 255, no wrap
  - clr_counters_i zeroes them on the next edge
  - clear takes priority over a simultaneous increment
- Latency: entering GEN_RST at edge N gives general_reset_o=1 for cycles N..N+RESET_CYCLES-1 and WAIT_TX at N+RESET_CYCLES. link_up_o rises on the edge that enters LINK_UP.

Test Plan:
- Reset release with pll=1, los=0, tx/rx_ready tied 1, RESET_CYCLES=4, RX_STABLE=8, LOS_FILTER=3 -> los_f clears after 3 cycles; general_reset_o 4 cycles; manual_reset_rx_o 4 cycles; link_up_o after 8 stable cycles; state ends at 5.
- gbt_tx_ready_i held 0, TX_TIMEOUT=10 -> GEN_RST re-entered every 14 cycles; gen_retry_cnt=3 after 3 loops; after 300 loops it holds 255.
- gbt_rx_ready_i held 0, MAX_RX_RETRIES=2, RX_TIMEOUT=10 -> sequence RX_RST, WAIT_RX, RX_RST, WAIT_RX, GEN_RST; rx_retry_cnt=2.
- In LINK_UP, drop rx_ready 1 cycle -> RX_RST, link_lost_cnt=1, link_up_o=0 next cycle. Drop tx and rx together -> GEN_RST, link_lost_cnt=2.
- sfp_los_i pulse of 2 cycles with LOS_FILTER=3 -> no state change. A 3-cycle pulse -> WAIT_PLL with general_reset_o=1; recovery when LOS deasserts for 3 cycles.
- Assert rstn_ir=0 for one cycle mid-WAIT_RX, and clr_counters_i coincident with a counter increment -> all outputs at reset values on the next edge; counter reads 0.
